// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder.
// FSM encodings, word size and the strobe mask helper.
package mem_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam int WORD_BYTES = 4;

  typedef struct packed {
    logic we;
    logic err;
  } req_t;

  function automatic logic [31:0] strb_mask(
    input logic [3:0] strb
  );
    logic [31:0] m;
    for (int i = 0; i < WORD_BYTES; i++) begin
      m[8*i +: 8] = {8{strb[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Word-organised single-port RAM.
// Byte write enables, registered read, no reset.
module mem_array
  import mem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];
  logic [31:0] mask;

  assign mask = strb_mask(be);

  always_ff @(posedge clk) begin
    if (|be) begin
      mem[addr] <= (mem[addr] & ~mask)
                 | (wdata & mask);
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle responder for the CPU data port.
// One request in flight; response after a fixed wait.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN =
    33'(DEPTH_WORDS) * 33'(WORD_BYTES);
  localparam logic [3:0] LAT = 4'(LATENCY);

  logic [1:0]    state;
  logic [3:0]    cnt;
  req_t          req_q;
  logic [AW-1:0] idx_q;

  logic          accept;
  logic          bad;
  logic [32:0]   diff;
  logic [AW-1:0] idx;
  logic [AW-1:0] ram_addr;
  logic [3:0]    ram_be;
  logic [31:0]   ram_rdata;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && req_ready;

  // Below-base addresses borrow into bit 32 and so land above SPAN.
  assign diff = {1'b0, req_addr}
              - {1'b0, BASE_ADDR};
  assign idx  = AW'(diff >> 2);
  assign bad  = (req_addr[1:0] != 2'b00)
             || (diff >= SPAN);

  // Read the request word while idle so the data is ready early.
  assign ram_addr = req_ready ? idx : idx_q;
  assign ram_be   = (accept && req_we && !bad)
                  ? req_wstrb : 4'b0000;

  mem_array #(
    .DEPTH (DEPTH_WORDS),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .be    (ram_be),
    .wdata (req_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      req_q     <= '0;
      idx_q     <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            state     <= WAIT;
            cnt       <= LAT;
            req_q.we  <= req_we;
            req_q.err <= bad;
            idx_q     <= idx;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state     <= RESP;
            rsp_err   <= req_q.err;
            rsp_rdata <= (req_q.we || req_q.err)
                       ? '0 : ram_rdata;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomised bench for data_mem_responder.
// Unit 0 uses LATENCY=2, unit 1 uses LATENCY=0.
module tb_data_mem_responder;

  localparam int DW = 1024;
  localparam int NW = 64;

  logic clk = 1'b0;
  logic reset;

  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_wstrb [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  logic [31:0] model [2][DW];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  data_mem_responder #(
    .DEPTH_WORDS (DW),
    .BASE_ADDR   (32'h0),
    .LATENCY     (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid[0]),
    .req_ready (req_ready[0]),
    .req_we    (req_we[0]),
    .req_addr  (req_addr[0]),
    .req_wdata (req_wdata[0]),
    .req_wstrb (req_wstrb[0]),
    .rsp_valid (rsp_valid[0]),
    .rsp_ready (rsp_ready[0]),
    .rsp_rdata (rsp_rdata[0]),
    .rsp_err   (rsp_err[0])
  );

  data_mem_responder #(
    .DEPTH_WORDS (DW),
    .BASE_ADDR   (32'h0),
    .LATENCY     (0)
  ) dut_z (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid[1]),
    .req_ready (req_ready[1]),
    .req_we    (req_we[1]),
    .req_addr  (req_addr[1]),
    .req_wdata (req_wdata[1]),
    .req_wstrb (req_wstrb[1]),
    .rsp_valid (rsp_valid[1]),
    .rsp_ready (rsp_ready[1]),
    .rsp_rdata (rsp_rdata[1]),
    .rsp_err   (rsp_err[1])
  );

  // Reference: byte-addressed word memory with range/alignment errors.
  function automatic void model_access(
    input int u, input logic we,
    input logic [31:0] a, input logic [31:0] wd,
    input logic [3:0] ws,
    output logic [31:0] rd, output logic er
  );
    er = (a % 4 != 0) || (a >= 4 * DW);
    rd = 32'h0;
    if (er) return;
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (ws[b]) model[u][a/4][8*b +: 8] = wd[8*b +: 8];
      end
    end else begin
      rd = model[u][a/4];
    end
  endfunction

  function automatic logic [31:0] rand_addr();
    int k = $urandom_range(0, 9);
    if (k == 0) return ($urandom_range(0, NW-1) * 4) | $urandom_range(1, 3);
    if (k == 1) return 32'h1000 + $urandom_range(0, 255) * 4;
    return $urandom_range(0, NW-1) * 4;
  endfunction

  task automatic xact(
    input int u, input logic we,
    input logic [31:0] a, input logic [31:0] wd,
    input logic [3:0] ws, input int hold,
    output int lat, output logic [31:0] rd, output logic er
  );
    @(negedge clk);
    vectors++;
    if (req_ready[u] !== 1'b1) begin
      miscompares++;
      $display("FAIL idle_ready u%0d: got %b want 1", u, req_ready[u]);
    end
    req_valid[u] = 1'b1; req_we[u] = we; req_addr[u] = a;
    req_wdata[u] = wd; req_wstrb[u] = ws;
    @(posedge clk); #1;
    // Keep a garbage store pending; it must be ignored while busy.
    req_we[u] = 1'b1; req_wstrb[u] = 4'hF;
    req_addr[u] = $urandom_range(0, NW-1) * 4; req_wdata[u] = $urandom;
    vectors++;
    if (req_ready[u] !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_ready u%0d: got %b want 0", u, req_ready[u]);
    end
    lat = 0;
    while (rsp_valid[u] !== 1'b1 && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    rd = rsp_rdata[u]; er = rsp_err[u];
    if (lat >= 40) begin
      req_valid[u] = 1'b0;
      vectors++; miscompares++;
      $display("FAIL rsp_timeout u%0d: got no rsp_valid want one", u);
      return;
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (rsp_valid[u] !== 1'b1 || rsp_rdata[u] !== rd ||
          rsp_err[u] !== er || req_ready[u] !== 1'b0) begin
        miscompares++;
        $display("FAIL hold_stable u%0d: got v=%b rd=%h e=%b rdy=%b want v=1 rd=%h e=%b rdy=0",
                 u, rsp_valid[u], rsp_rdata[u], rsp_err[u], req_ready[u], rd, er);
      end
    end
    @(negedge clk);
    req_valid[u] = 1'b0; rsp_ready[u] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[u] = 1'b0;
    vectors++;
    if (rsp_valid[u] !== 1'b0 || req_ready[u] !== 1'b1 ||
        rsp_rdata[u] !== rd || rsp_err[u] !== er) begin
      miscompares++;
      $display("FAIL release u%0d: got v=%b rdy=%b rd=%h e=%b want v=0 rdy=1 rd=%h e=%b",
               u, rsp_valid[u], req_ready[u], rsp_rdata[u], rsp_err[u], rd, er);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int u = 0; u < 2; u++) begin
      req_valid[u] = 1'b0; req_we[u] = 1'b0; req_addr[u] = '0;
      req_wdata[u] = '0; req_wstrb[u] = '0; rsp_ready[u] = 1'b0;
    end
    #2 reset = 1'b0;
    #20;
    for (int u = 0; u < 2; u++) begin
      vectors++;
      if (req_ready[u] !== 1'b1 || rsp_valid[u] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_hs u%0d: got rdy=%b v=%b want rdy=1 v=0",
                 u, req_ready[u], rsp_valid[u]);
      end
      vectors++;
      if (rsp_rdata[u] !== 32'h0 || rsp_err[u] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_rsp u%0d: got rd=%h e=%b want rd=0 e=0",
                 u, rsp_rdata[u], rsp_err[u]);
      end
    end
    @(negedge clk) reset = 1'b1;
  endtask

  task automatic test_preload();
    int lat; logic [31:0] rd, erd; logic er, eer, wd;
    for (int u = 0; u < 2; u++) begin
      for (int w = 0; w < NW; w++) begin
        logic [31:0] d = $urandom;
        xact(u, 1'b1, w * 4, d, 4'hF, 0, lat, rd, er);
        model_access(u, 1'b1, w * 4, d, 4'hF, erd, eer);
        vectors++;
        if (rd !== erd || er !== eer) begin
          miscompares++;
          $display("FAIL preload u%0d w%0d: got rd=%h e=%b want rd=%h e=%b",
                   u, w, rd, er, erd, eer);
        end
      end
    end
    wd = 1'b0;
  endtask

  task automatic test_first_load();
    int lat; logic [31:0] rd, erd; logic er, eer;
    xact(0, 1'b0, 32'h0, 32'h0, 4'h0, 0, lat, rd, er);
    model_access(0, 1'b0, 32'h0, 32'h0, 4'h0, erd, eer);
    vectors++;
    if (lat != 3) begin
      miscompares++;
      $display("FAIL latency2: got %0d edges want 3", lat);
    end
    vectors++;
    if (rd !== erd || er !== eer) begin
      miscompares++;
      $display("FAIL load0: got rd=%h e=%b want rd=%h e=%b", rd, er, erd, eer);
    end
  endtask

  task automatic test_byte_strobe();
    int lat; logic [31:0] rd, erd; logic er, eer;
    xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, lat, rd, er);
    model_access(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, erd, eer);
    xact(0, 1'b1, 32'h10, 32'h000000AA, 4'h1, 0, lat, rd, er);
    model_access(0, 1'b1, 32'h10, 32'h000000AA, 4'h1, erd, eer);
    xact(0, 1'b1, 32'h10, 32'h12345678, 4'h0, 0, lat, rd, er);
    model_access(0, 1'b1, 32'h10, 32'h12345678, 4'h0, erd, eer);
    xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, lat, rd, er);
    vectors++;
    if (rd !== 32'hDEADBEAA || er !== 1'b0) begin
      miscompares++;
      $display("FAIL byte_strobe: got rd=%h e=%b want rd=deadbeaa e=0", rd, er);
    end
  endtask

  task automatic test_errors();
    int lat; logic [31:0] rd, d, erd; logic er, eer;
    xact(0, 1'b0, 32'h12, 32'h0, 4'h0, 0, lat, rd, er);
    vectors++;
    if (rd !== 32'h0 || er !== 1'b1) begin
      miscompares++;
      $display("FAIL misaligned: got rd=%h e=%b want rd=0 e=1", rd, er);
    end
    xact(0, 1'b0, 32'h1000, 32'h0, 4'h0, 0, lat, rd, er);
    vectors++;
    if (rd !== 32'h0 || er !== 1'b1) begin
      miscompares++;
      $display("FAIL out_of_range: got rd=%h e=%b want rd=0 e=1", rd, er);
    end
    d = $urandom;
    xact(0, 1'b1, 32'h1000, d, 4'hF, 0, lat, rd, er);
    vectors++;
    if (er !== 1'b1) begin
      miscompares++;
      $display("FAIL oob_store_err: got e=%b want 1", er);
    end
    xact(0, 1'b0, 32'h0, 32'h0, 4'h0, 0, lat, rd, er);
    model_access(0, 1'b0, 32'h0, 32'h0, 4'h0, erd, eer);
    vectors++;
    if (rd !== erd || er !== 1'b0) begin
      miscompares++;
      $display("FAIL no_alias: got rd=%h e=%b want rd=%h e=0", rd, er, erd);
    end
    xact(0, 1'b1, 32'hFFC, d, 4'hF, 0, lat, rd, er);
    model_access(0, 1'b1, 32'hFFC, d, 4'hF, erd, eer);
    xact(0, 1'b0, 32'hFFC, 32'h0, 4'h0, 0, lat, rd, er);
    vectors++;
    if (rd !== d || er !== 1'b0) begin
      miscompares++;
      $display("FAIL top_word: got rd=%h e=%b want rd=%h e=0", rd, er, d);
    end
  endtask

  task automatic test_hold();
    int lat; logic [31:0] rd, erd; logic er, eer;
    xact(0, 1'b0, 32'h8, 32'h0, 4'h0, 5, lat, rd, er);
    model_access(0, 1'b0, 32'h8, 32'h0, 4'h0, erd, eer);
    vectors++;
    if (rd !== erd || er !== eer) begin
      miscompares++;
      $display("FAIL hold_data: got rd=%h e=%b want rd=%h e=%b", rd, er, erd, eer);
    end
  endtask

  task automatic test_random();
    int lat; logic [31:0] rd, erd, a, d; logic er, eer, we; logic [3:0] ws;
    for (int n = 0; n < 40; n++) begin
      we = 1'($urandom); a = rand_addr(); d = $urandom; ws = 4'($urandom);
      xact(0, we, a, d, ws, $urandom_range(0, 3), lat, rd, er);
      model_access(0, we, a, d, ws, erd, eer);
      vectors++;
      if (rd !== erd || er !== eer || lat != 3) begin
        miscompares++;
        $display("FAIL random n%0d we=%b a=%h: got rd=%h e=%b lat=%0d want rd=%h e=%b lat=3",
                 n, we, a, rd, er, lat, erd, eer);
      end
    end
  endtask

  task automatic test_reset_wait();
    int lat; logic [31:0] rd, erd, d; logic er, eer, ghost;
    xact(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, lat, rd, er);
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 32'h20;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(posedge clk); #2;
    reset = 1'b0; #1;
    vectors++;
    if (req_ready[0] !== 1'b1 || rsp_valid[0] !== 1'b0 ||
        rsp_rdata[0] !== 32'h0 || rsp_err[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: got rdy=%b v=%b rd=%h e=%b want 1 0 0 0",
               req_ready[0], rsp_valid[0], rsp_rdata[0], rsp_err[0]);
    end
    @(negedge clk) reset = 1'b1;
    ghost = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (rsp_valid[0] !== 1'b0) ghost = 1'b1;
    end
    vectors++;
    if (ghost !== 1'b0) begin
      miscompares++;
      $display("FAIL dropped_rsp: got rsp_valid after reset want none");
    end
    d = $urandom;
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h24;
    req_wdata[0] = d; req_wstrb[0] = 4'hF;
    model_access(0, 1'b1, 32'h24, d, 4'hF, erd, eer);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    #2 reset = 1'b0;
    @(negedge clk) reset = 1'b1;
    xact(0, 1'b0, 32'h24, 32'h0, 4'h0, 0, lat, rd, er);
    vectors++;
    if (rd !== d || er !== 1'b0) begin
      miscompares++;
      $display("FAIL store_survives: got rd=%h e=%b want rd=%h e=0", rd, er, d);
    end
  endtask

  task automatic test_back_to_back();
    int lat, sent, got, cyc;
    logic [31:0] rd, erd, a, d; logic er, eer, we; logic [3:0] ws;
    logic [31:0] q_rd [$];
    logic        q_er [$];
    xact(1, 1'b0, 32'h4, 32'h0, 4'h0, 0, lat, rd, er);
    model_access(1, 1'b0, 32'h4, 32'h0, 4'h0, erd, eer);
    vectors++;
    if (lat != 1 || rd !== erd || er !== eer) begin
      miscompares++;
      $display("FAIL latency0: got lat=%0d rd=%h e=%b want lat=1 rd=%h e=%b",
               lat, rd, er, erd, eer);
    end
    sent = 0; got = 0; cyc = 0;
    rsp_ready[1] = 1'b1;
    while (got < 30 && cyc < 400) begin
      @(negedge clk);
      if (req_ready[1] && sent < 30) begin
        we = 1'($urandom); a = rand_addr(); d = $urandom; ws = 4'($urandom);
        req_valid[1] = 1'b1; req_we[1] = we; req_addr[1] = a;
        req_wdata[1] = d; req_wstrb[1] = ws;
        model_access(1, we, a, d, ws, erd, eer);
        q_rd.push_back(erd); q_er.push_back(eer);
        sent++;
      end else begin
        req_valid[1] = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
      if (rsp_valid[1] === 1'b1) begin
        vectors++;
        if (q_rd.size() == 0) begin
          miscompares++;
          $display("FAIL b2b_spurious: got rsp_valid want none pending");
        end else begin
          erd = q_rd.pop_front(); eer = q_er.pop_front();
          if (rsp_rdata[1] !== erd || rsp_err[1] !== eer) begin
            miscompares++;
            $display("FAIL b2b n%0d: got rd=%h e=%b want rd=%h e=%b",
                     got, rsp_rdata[1], rsp_err[1], erd, eer);
          end
        end
        got++;
      end
    end
    @(posedge clk); #1;
    req_valid[1] = 1'b0; rsp_ready[1] = 1'b0;
    vectors++;
    if (got != 30 || req_ready[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_done: got %0d rsp rdy=%b want 30 rsp rdy=1", got, req_ready[1]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_preload();
    test_first_load();
    test_byte_strobe();
    test_errors();
    test_hold();
    test_random();
    test_reset_wait();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
